wchb_join_n: RTL and testbench
==============================

Name: wchb_join_n

Overview:
Clocked, parametrised N-channel join for 4-phase bundled-data channels.
- Waits for a request token on every input channel and captures each channel's data.
- Emits one combined token downstream and returns the downstream acknowledge to all inputs (weak-conditioned half-buffer behaviour).
- Synchronous successor of the two-input C-element join; used where async-style pipeline stages are wrapped into the clocked domain.

Parameters:
N_CH, 2, number of input channels (>=2)
DATA_W, 32, data width per channel
INIT, 0, reset token state: 0 = empty, 1 = token present (o_req high, o_data zero)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
i_req  input  N_CH  per-channel 4-phase request
o_ack  output  N_CH  per-channel acknowledge; all bits always equal
i_data  input  N_CH*DATA_W  bundled data; channel k at bits [k*DATA_W +: DATA_W]
o_req  output  1  joined request
i_ack  input  1  downstream acknowledge
o_data  output  N_CH*DATA_W  captured joined data, same packing as i_data
o_err  output  1  sticky protocol-error flag

Behaviour:
- Registered state machine; all outputs come from registers.
- Per-channel bits:
  - arrived[N_CH]: request seen high.
  - released[N_CH]: request seen low after ack.
- States:
  - S_EMPTY: o_req=0, o_ack=0.
    - Each cycle, for every k with i_req[k]=1 and arrived[k]=0: set arrived[k] and capture i_data slice k into o_data slice k.
    - When (arrived | i_req) is all-ones: go to S_FULL.
    - Latency: the last request sampled high in cycle t gives o_req=1 in cycle t+1.
  - S_FULL: o_req=1, o_ack=0, o_data stable. When i_ack=1: go to S_ACKD.
  - S_ACKD: o_req=1, o_ack=all-ones.
    - Set released[k] when i_req[k]=0.
    - When (released | ~i_req) is all-ones: go to S_RTZ. This is the C-element hysteresis: o_req falls only after all inputs fall.
  - S_RTZ: o_req=0, o_ack=all-ones. When i_ack=0: go to S_EMPTY, o_ack=0, clear arrived and released.
- o_data holds its value in all states except during capture in S_EMPTY.
- Simultaneous events: several channels arriving in the same cycle are all captured that cycle. All channels arriving together in one cycle goes directly to S_FULL next cycle.
- Protocol errors (set o_err, which stays set until rst; the state machine continues unaffected):
  - i_req[k] falls in S_EMPTY while arrived[k]=1 (token withdrawn). Data is not recaptured.
  - i_ack=1 while in S_EMPTY.
  - i_req[k] rises again in S_ACKD after released[k]=1.
- Reset:
  - rst sampled high forces, next edge: o_err=0, arrived=0, released=0, o_data=0, o_ack=0.
  - INIT=0: state S_EMPTY, o_req=0.
  - INIT=1: state S_FULL, o_req=1.
  - Reset mid-handshake discards any in-flight token without error.
- Single-channel degenerate case is not supported; N_CH<2 is an elaboration error.

Optional Feature:
Macro WCHB_JOIN_SYNC_EN.
- Defined: i_req and i_ack each pass through a two-flop synchronizer before the state machine.
  - Adds 2 cycles latency on every transition.
  - Data is still sampled directly from i_data; the 4-phase protocol guarantees stability while req is high.
  - Synchronizer flops reset to 0, or i_ack-side to 0 and req-side to 0 regardless of INIT.
- Undefined: inputs are sampled directly; latencies as listed above.

Decomposition:
- Package wchb_pkg:
  - State enum typedef (S_EMPTY, S_FULL, S_ACKD, S_RTZ).
  - Function returning the all-ones N-bit check.
  - Shared reset-value constants.
- Sub-module wchb_sync: parametrised-width two-flop synchronizer, instantiated only under WCHB_JOIN_SYNC_EN.
- Datapath capture and FSM stay in wchb_join_n.

Test Plan:
- N_CH=3, DATA_W=8, INIT=0, no macro:
  - Raise i_req[0] (data 0x11) at t0, i_req[2] (0x33) at t2, i_req[1] (0x22) at t5 -> o_req=1 at t6, o_data=0x332211.
  - i_ack=1 -> o_ack=3'b111 next cycle.
- Full handshake: drop i_req[1] only -> o_req stays 1. Drop the remaining reqs -> o_req=0 next cycle. i_ack=0 -> o_ack=0 next cycle, state S_EMPTY, second token accepted normally.
- All three reqs rise in the same cycle t -> o_req=1 at t+1 with all slices captured.
- Protocol errors:
  - Raise then drop i_req[0] in S_EMPTY -> o_err=1 next cycle and stays 1.
  - i_ack=1 in S_EMPTY -> o_err=1.
- INIT=1: rst held 2 cycles -> o_req=1, o_data=0, o_ack=0. i_ack=1 -> o_ack all-ones.
- Reset mid-operation: assert rst in S_ACKD -> next edge o_req=0 (INIT=0), o_ack=0, o_err=0.
- With WCHB_JOIN_SYNC_EN: the first scenario gives o_req=1 at t8.

Source files
------------

// File: rtl/wchb_pkg.sv
// Shared types and helpers for the clocked WCHB join.
// Holds the handshake state encoding, the "every channel set" test and
// the values that registers take on reset.
package wchb_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_ACKD  = 2'd2,
      S_RTZ   = 2'd3
   } state_t;

   // Widest channel vector all_set() can inspect; callers zero-extend into it.
   localparam int unsigned WCHB_MAX_CH = 64;

   localparam logic RST_ERR  = 1'b0;
   localparam logic RST_SYNC = 1'b0;

   // True when bits [n-1:0] of v are all ones; bits at n and above are ignored.
   function automatic logic all_set(input logic [WCHB_MAX_CH-1:0] v,
                                    input int unsigned            n);
      logic r;
      r = 1'b1;
      for (int unsigned i = 0; i < WCHB_MAX_CH; i++) begin
         if ((i < n) && !v[i]) begin
            r = 1'b0;
         end
      end
      return r;
   endfunction

   // Reset state: a pre-loaded token starts out already presented downstream.
   function automatic state_t reset_state(input int init);
      return (init != 0) ? S_FULL : S_EMPTY;
   endfunction

   function automatic logic reset_req(input int init);
      return (init != 0);
   endfunction

endpackage

// File: rtl/wchb_sync.sv
// Two-flop synchronizer of parametrised width, reset to zero.
module wchb_sync
   import wchb_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_reg;
   logic [W-1:0] sync_reg;

   // Two register stages; the first may go metastable, the second is used.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= {W{RST_SYNC}};
         sync_reg <= {W{RST_SYNC}};
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/wchb_join_n.sv
// N-channel join for 4-phase bundled-data channels in the clocked domain.
// Collects one token per input, presents the joined token downstream and
// returns the downstream acknowledge to every input; o_req only falls once
// every input request has fallen (C-element hysteresis).
// Optional macro WCHB_JOIN_SYNC_EN: pass i_req/i_ack through two-flop
// synchronizers (two extra cycles on every transition); data stays direct.
module wchb_join_n
   import wchb_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int DATA_W = 32,
   parameter int INIT   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        i_req,
   output logic [N_CH-1:0]        o_ack,
   input  logic [N_CH*DATA_W-1:0] i_data,
   output logic                   o_req,
   input  logic                   i_ack,
   output logic [N_CH*DATA_W-1:0] o_data,
   output logic                   o_err
);

   generate
      if (N_CH < 2) begin : g_bad_n_ch
         $error("wchb_join_n: N_CH must be at least 2");
      end
      if (N_CH > int'(WCHB_MAX_CH)) begin : g_big_n_ch
         $error("wchb_join_n: N_CH exceeds WCHB_MAX_CH");
      end
   endgenerate

   logic [N_CH-1:0] req_s;
   logic            ack_s;

`ifdef WCHB_JOIN_SYNC_EN
   logic [N_CH:0] sync_q;

   wchb_sync #(.W(N_CH + 1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({i_ack, i_req}),
      .q   (sync_q)
   );

   assign req_s = sync_q[N_CH-1:0];
   assign ack_s = sync_q[N_CH];
`else
   assign req_s = i_req;
   assign ack_s = i_ack;
`endif

   state_t                  state_reg, state_next;
   logic [N_CH-1:0]         arrived_reg, arrived_next;
   logic [N_CH-1:0]         released_reg, released_next;
   logic [N_CH*DATA_W-1:0]  data_reg, data_next;
   logic                    err_reg, err_next;
   logic                    req_reg;
   logic [N_CH-1:0]         ack_reg;
   logic [N_CH-1:0]         capture;

   // Per-channel capture: the first cycle a request is seen high while empty.
   // A withdrawn-and-reraised request is not recaptured (arrived stays set).
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_chan
         assign capture[gi] = (state_reg == S_EMPTY) && req_s[gi] && !arrived_reg[gi];
         assign data_next[gi*DATA_W +: DATA_W] = capture[gi]
                                               ? i_data[gi*DATA_W +: DATA_W]
                                               : data_reg[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Next-state logic, per-channel bookkeeping and protocol-error detection.
   always_comb begin
      state_next    = state_reg;
      arrived_next  = arrived_reg;
      released_next = released_reg;
      err_next      = err_reg;
      case (state_reg)
         S_EMPTY: begin
            arrived_next = arrived_reg | req_s;
            if (((arrived_reg & ~req_s) != '0) || ack_s) begin
               err_next = 1'b1;
            end
            if (all_set(WCHB_MAX_CH'(arrived_reg | req_s), N_CH)) begin
               state_next = S_FULL;
            end
         end
         S_FULL: begin
            if (ack_s) begin
               state_next = S_ACKD;
            end
         end
         S_ACKD: begin
            released_next = released_reg | ~req_s;
            if ((released_reg & req_s) != '0) begin
               err_next = 1'b1;
            end
            if (all_set(WCHB_MAX_CH'(released_reg | ~req_s), N_CH)) begin
               state_next = S_RTZ;
            end
         end
         S_RTZ: begin
            if (!ack_s) begin
               state_next    = S_EMPTY;
               arrived_next  = '0;
               released_next = '0;
            end
         end
         default: begin
            state_next = S_EMPTY;
         end
      endcase
   end

   // State and output registers; outputs are decoded from the next state so
   // they change on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= reset_state(INIT);
         req_reg      <= reset_req(INIT);
         ack_reg      <= '0;
         arrived_reg  <= '0;
         released_reg <= '0;
         data_reg     <= '0;
         err_reg      <= RST_ERR;
      end else begin
         state_reg    <= state_next;
         req_reg      <= (state_next == S_FULL) || (state_next == S_ACKD);
         ack_reg      <= {N_CH{(state_next == S_ACKD) || (state_next == S_RTZ)}};
         arrived_reg  <= arrived_next;
         released_reg <= released_next;
         data_reg     <= data_next;
         err_reg      <= err_next;
      end
   end

   assign o_req  = req_reg;
   assign o_ack  = ack_reg;
   assign o_data = data_reg;
   assign o_err  = err_reg;

endmodule

// File: tb/tb_wchb_join_n.sv
// Self-checking bench for wchb_join_n (N_CH=3, DATA_W=8), INIT=0 and INIT=1.
module tb_wchb_join_n;

`ifdef WCHB_JOIN_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int NC = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, rst_1;
   logic [NC-1:0] i_req, i_req_1, o_ack, o_ack_1;
   logic [NC*DW-1:0] i_data, i_data_1, o_data, o_data_1;
   logic          i_ack, i_ack_1, o_req, o_req_1, o_err, o_err_1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wchb_join_n #(.N_CH(NC), .DATA_W(DW), .INIT(0)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .o_ack(o_ack), .i_data(i_data),
      .o_req(o_req), .i_ack(i_ack), .o_data(o_data), .o_err(o_err));

   wchb_join_n #(.N_CH(NC), .DATA_W(DW), .INIT(1)) dut_1 (
      .clk(clk), .rst(rst_1), .i_req(i_req_1), .o_ack(o_ack_1), .i_data(i_data_1),
      .o_req(o_req_1), .i_ack(i_ack_1), .o_data(o_data_1), .o_err(o_err_1));

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; i_req = '0; i_ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Complete a well-behaved handshake on the INIT=0 instance (drive only).
   task automatic drive_release();
      i_ack = 1'b1; tick(1 + LAT);
      i_req = '0;   tick(1 + LAT);
      i_ack = 1'b0; tick(1 + LAT);
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_1 = 1'b1;
      i_req = '0; i_ack = 1'b0; i_data = '0;
      i_req_1 = '0; i_ack_1 = 1'b0; i_data_1 = '0;
      tick(2);
      rst = 1'b0; rst_1 = 1'b0;
      checks++;
      if ({o_req, o_ack, o_data, o_err} !== {1'b0, 3'b000, 24'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset0: got req=%b ack=%b data=%h err=%b want 0/000/000000/0",
                  o_req, o_ack, o_data, o_err);
      end
      $display("reset: INIT=0 req=%b ack=%b data=%h err=%b", o_req, o_ack, o_data, o_err);
   endtask

   task automatic test_staggered();
      i_data[0*DW +: DW] = 8'h11; i_req[0] = 1'b1; tick(2);
      i_data[2*DW +: DW] = 8'h33; i_req[2] = 1'b1; tick(3);
      i_data[1*DW +: DW] = 8'h22; i_req[1] = 1'b1;
      tick(LAT);
      checks++;
      if (o_req !== 1'b0) begin
         errors++; $display("FAIL stag_early: o_req=%b want 0", o_req);
      end
      tick();
      checks++;
      if (o_req !== 1'b1 || o_data !== 24'h332211) begin
         errors++; $display("FAIL stag_join: req=%b data=%h want 1/332211", o_req, o_data);
      end
      i_ack = 1'b1; tick(1 + LAT);
      checks++;
      if (o_ack !== 3'b111 || o_req !== 1'b1) begin
         errors++; $display("FAIL stag_ack: ack=%b req=%b want 111/1", o_ack, o_req);
      end
      i_req[1] = 1'b0; tick(1 + LAT + 2);
      checks++;
      if (o_req !== 1'b1) begin
         errors++; $display("FAIL stag_hyst: o_req=%b want 1", o_req);
      end
      i_req = '0; tick(1 + LAT);
      checks++;
      if (o_req !== 1'b0 || o_ack !== 3'b111) begin
         errors++; $display("FAIL stag_rtz: req=%b ack=%b want 0/111", o_req, o_ack);
      end
      i_ack = 1'b0; tick(1 + LAT);
      checks++;
      if (o_ack !== 3'b000 || o_err !== 1'b0 || o_data !== 24'h332211) begin
         errors++; $display("FAIL stag_done: ack=%b err=%b data=%h want 000/0/332211",
                            o_ack, o_err, o_data);
      end
      $display("staggered: joined data %h", o_data);
   endtask

   task automatic test_simultaneous();
      logic [NC*DW-1:0] d;
      d = 24'($urandom);
      i_data = d; i_req = '1;
      tick(1 + LAT);
      checks++;
      if (o_req !== 1'b1 || o_data !== d) begin
         errors++; $display("FAIL simul: req=%b data=%h want 1/%h", o_req, o_data, d);
      end
      $display("simultaneous: data %h", o_data);
      drive_release();
   endtask

   // Random well-behaved environment; expectations come from protocol rules:
   // o_req rises 1+LAT cycles after the last request, carries each channel's
   // data as it was when that channel requested, and falls only after the
   // last request drops.
   task automatic test_random();
      logic [NC*DW-1:0] exp_d;
      int dly [NC];
      int ord [NC];
      int last, tmp, j;
      for (int tok = 0; tok < 30; tok++) begin
         last = 0;
         for (int k = 0; k < NC; k++) begin
            dly[k] = $urandom_range(0, 4);
            if (dly[k] > last) last = dly[k];
            exp_d[k*DW +: DW] = 8'($urandom);
            ord[k] = k;
         end
         for (int c = 0; c <= last + LAT + 1; c++) begin
            for (int k = 0; k < NC; k++) begin
               if (dly[k] == c) begin
                  i_data[k*DW +: DW] = exp_d[k*DW +: DW];
                  i_req[k] = 1'b1;
               end
            end
            tick();
            checks++;
            if (o_req !== (c >= last + LAT) || o_ack !== 3'b000) begin
               errors++;
               $display("FAIL rnd_req tok%0d c%0d: req=%b ack=%b want %b/000",
                        tok, c, o_req, o_ack, (c >= last + LAT));
            end
         end
         checks++;
         if (o_data !== exp_d) begin
            errors++; $display("FAIL rnd_data tok%0d: got %h want %h", tok, o_data, exp_d);
         end
         tick($urandom_range(0, 2));
         i_ack = 1'b1; tick(1 + LAT);
         checks++;
         if (o_ack !== 3'b111) begin
            errors++; $display("FAIL rnd_ack tok%0d: got %b want 111", tok, o_ack);
         end
         for (int k = NC - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
         end
         for (int k = 0; k < NC; k++) begin
            i_req[ord[k]] = 1'b0;
            i_data[ord[k]*DW +: DW] = 8'($urandom);
            tick(1 + LAT);
            checks++;
            if (o_req !== (k != NC - 1)) begin
               errors++; $display("FAIL rnd_drop tok%0d k%0d: req=%b want %b",
                                  tok, k, o_req, (k != NC - 1));
            end
         end
         i_ack = 1'b0; tick(1 + LAT);
         checks++;
         if (o_ack !== 3'b000 || o_err !== 1'b0 || o_data !== exp_d) begin
            errors++; $display("FAIL rnd_end tok%0d: ack=%b err=%b data=%h want 000/0/%h",
                               tok, o_ack, o_err, o_data, exp_d);
         end
         $display("random token %0d: data %h", tok, exp_d);
      end
   endtask

   task automatic test_err_withdraw();
      do_reset();
      i_data[0*DW +: DW] = 8'h5A; i_req[0] = 1'b1; tick(1 + LAT);
      checks++;
      if (o_err !== 1'b0) begin
         errors++; $display("FAIL wd_pre: o_err=%b want 0", o_err);
      end
      i_req[0] = 1'b0; tick(1 + LAT);
      checks++;
      if (o_err !== 1'b1) begin
         errors++; $display("FAIL wd_err: o_err=%b want 1", o_err);
      end
      tick(3);
      checks++;
      if (o_err !== 1'b1 || o_req !== 1'b0) begin
         errors++; $display("FAIL wd_sticky: err=%b req=%b want 1/0", o_err, o_req);
      end
      do_reset();
      checks++;
      if (o_err !== 1'b0) begin
         errors++; $display("FAIL wd_clear: o_err=%b want 0", o_err);
      end
      $display("withdraw error: flagged and cleared by reset");
   endtask

   task automatic test_err_ack();
      do_reset();
      i_ack = 1'b1; tick(1 + LAT);
      checks++;
      if (o_err !== 1'b1 || o_req !== 1'b0 || o_ack !== 3'b000) begin
         errors++; $display("FAIL ackerr: err=%b req=%b ack=%b want 1/0/000",
                            o_err, o_req, o_ack);
      end
      $display("ack-in-empty error: err=%b", o_err);
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [NC*DW-1:0] d;
      i_data = 24'hC0FFEE; i_req = '1; tick(1 + LAT);
      i_ack = 1'b1; tick(1 + LAT);
      checks++;
      if (o_ack !== 3'b111 || o_req !== 1'b1) begin
         errors++; $display("FAIL mid_ackd: ack=%b req=%b want 111/1", o_ack, o_req);
      end
      rst = 1'b1; i_req = '0; i_ack = 1'b0; tick();
      rst = 1'b0;
      checks++;
      if ({o_req, o_ack, o_err, o_data} !== {1'b0, 3'b000, 1'b0, 24'h0}) begin
         errors++; $display("FAIL mid_rst: req=%b ack=%b err=%b data=%h want 0/000/0/000000",
                            o_req, o_ack, o_err, o_data);
      end
      d = 24'($urandom);
      i_data = d; i_req = '1; tick(1 + LAT);
      checks++;
      if (o_req !== 1'b1 || o_data !== d) begin
         errors++; $display("FAIL mid_next: req=%b data=%h want 1/%h", o_req, o_data, d);
      end
      $display("reset mid-handshake: next token %h", o_data);
      drive_release();
   endtask

   task automatic test_init1();
      i_ack_1 = 1'b1; tick(1 + LAT);
      rst_1 = 1'b1; i_ack_1 = 1'b0; tick(2);
      rst_1 = 1'b0;
      checks++;
      if ({o_req_1, o_ack_1, o_data_1, o_err_1} !== {1'b1, 3'b000, 24'h0, 1'b0}) begin
         errors++; $display("FAIL init1_rst: req=%b ack=%b data=%h err=%b want 1/000/000000/0",
                            o_req_1, o_ack_1, o_data_1, o_err_1);
      end
      i_ack_1 = 1'b1; tick(1 + LAT);
      checks++;
      if (o_ack_1 !== 3'b111 || o_req_1 !== 1'b1) begin
         errors++; $display("FAIL init1_ack: ack=%b req=%b want 111/1", o_ack_1, o_req_1);
      end
      tick();
      checks++;
      if (o_req_1 !== 1'b0) begin
         errors++; $display("FAIL init1_rtz: req=%b want 0", o_req_1);
      end
      i_ack_1 = 1'b0; tick(1 + LAT);
      checks++;
      if (o_ack_1 !== 3'b000 || o_err_1 !== 1'b0) begin
         errors++; $display("FAIL init1_done: ack=%b err=%b want 000/0", o_ack_1, o_err_1);
      end
      $display("INIT=1: preloaded token consumed");
   endtask

   initial begin
      test_reset();
      test_staggered();
      test_simultaneous();
      do_reset();
      test_random();
      test_err_withdraw();
      test_err_ack();
      test_reset_mid();
      test_init1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
